// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: command encodings,
// controller states and default latencies.
package mdu_pkg;

  // Command encodings carried on the op port
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Default datapath width and busy latencies
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Controller states
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // True for the commands that occupy the unit for a multi-cycle latency
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for the divide commands, which use the longer latency
  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational multiply/divide result generator. Produces the HI/LO pair
// for MULT/MULTU/DIV/DIVU, including the signed-overflow and divide-by-zero
// results. Other op codes yield zero (the top never latches them).
module mdu_compute
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Absolute value of a two's-complement operand as an unsigned magnitude.
  // The most negative value maps to 2^(WIDTH-1), which fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Re-apply a sign to an unsigned magnitude
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  logic signed [2*WIDTH-1:0] a_sx;
  logic signed [2*WIDTH-1:0] b_sx;
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;

  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] udivisor;
  logic [WIDTH-1:0] sdivisor;
  logic [WIDTH-1:0] qu;
  logic [WIDTH-1:0] ru;
  logic [WIDTH-1:0] qs_mag;
  logic [WIDTH-1:0] rs_mag;

  // Products: sign-extend for MULT, zero-extend for MULTU
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Division works on magnitudes; a zero divisor is replaced by one so the
  // dividers never see /0 (the result is overridden below anyway).
  assign a_neg    = a[WIDTH-1];
  assign b_neg    = b[WIDTH-1];
  assign div_zero = (b == '0);
  assign div_ovf  = (a == MOST_NEG) && (b == ALL_ONES);
  assign a_mag    = magnitude(a);
  assign b_mag    = magnitude(b);
  assign udivisor = div_zero ? ONE : b;
  assign sdivisor = div_zero ? ONE : b_mag;
  assign qu       = a / udivisor;
  assign ru       = a % udivisor;
  assign qs_mag   = a_mag / sdivisor;
  assign rs_mag   = a_mag % sdivisor;

  // Result selection per command, with the special divide cases first
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      OP_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      OP_DIV: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = ALL_ONES;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = a;
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend
          res_lo = apply_sign(qs_mag, a_neg ^ b_neg);
          res_hi = apply_sign(rs_mag, a_neg);
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = ALL_ONES;
        end else begin
          res_hi = ru;
          res_lo = qu;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers. A command
// is accepted only while idle; the result is computed at accept time into
// pending registers and exposed on HI/LO when the busy latency expires.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             finish;
  logic             write_hi;
  logic             write_lo;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] pend_hi_p1;
  logic [WIDTH-1:0] pend_lo_p1;

  mdu_compute #(
    .WIDTH (WIDTH)
  ) u_compute (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign busy = (state_q == BUSY);

  // Next-state, counter and register-write decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    finish   = 1'b0;
    write_hi = 1'b0;
    write_lo = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_muldiv(op)) begin
            accept  = 1'b1;
            state_d = BUSY;
            cnt_d   = is_div(op) ? DIV_LOAD : MULT_LOAD;
          end else if (op == OP_MTHI) begin
            write_hi = 1'b1;
          end else if (op == OP_MTLO) begin
            write_lo = 1'b1;
          end
        end
      end
      BUSY: begin
        // Any start seen here is ignored
        if (cnt_q == CNT_ONE) begin
          finish  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller state and busy counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage p1: capture the result of the accepted command until it retires
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_hi_p1 <= res_hi;
      pend_lo_p1 <= res_lo;
    end
  end

  // Architectural HI/LO: retire pending result or take MTHI/MTLO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      hi <= pend_hi_p1;
      lo <= pend_lo_p1;
    end else begin
      if (write_hi) hi <= a;
      if (write_lo) lo <= a;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a 32-bit instance with default
// latencies and a 16-bit instance with short latencies, driven by directed
// and random commands and compared against an arithmetic reference model.
module tb_mult_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start0;
  logic [2:0]  op0;
  logic [31:0] a0, b0;
  logic        busy0;
  logic [31:0] hi0, lo0;

  logic        start1;
  logic [2:0]  op1;
  logic [15:0] a1, b1;
  logic        busy1;
  logic [15:0] hi1, lo1;

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0),
    .busy(busy0), .hi(hi0), .lo(lo0)
  );

  mult_div_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .hi(hi1), .lo(lo1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  int lat_mul [2] = '{5, 1};
  int lat_div [2] = '{10, 3};
  int wid     [2] = '{32, 16};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Reference: plain integer arithmetic on sign/zero-extended values
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, q, r;
    logic [31:0] rh, rl;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    rh = '0;
    rl = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); rh = 32'((p >> w) & mask); rl = 32'(p & mask); end
      3'd1: begin p = ua * ub;      rh = 32'((p >> w) & mask); rl = 32'(p & mask); end
      3'd2: begin
        if (sb == 0) begin rh = 32'(ua); rl = 32'(mask); end
        else begin q = sa / sb; r = sa % sb; rl = 32'(64'(q) & mask); rh = 32'(64'(r) & mask); end
      end
      3'd3: begin
        if (ub == 0) begin rh = 32'(ua); rl = 32'(mask); end
        else begin rl = 32'(ua / ub); rh = 32'(ua % ub); end
      end
      default: ;
    endcase
    return {rh, rl};
  endfunction

  task automatic drive(input int d, input logic s, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    if (d == 0) begin start0 = s; op0 = o; a0 = x; b0 = y; end
    else begin start1 = s; op1 = o; a1 = x[15:0]; b1 = y[15:0]; end
  endtask

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction
  function automatic logic [31:0] get_hi(input int d);
    return (d == 0) ? hi0 : {16'd0, hi1};
  endfunction
  function automatic logic [31:0] get_lo(input int d);
    return (d == 0) ? lo0 : {16'd0, lo1};
  endfunction

  // Issue a multi-cycle command at a falling edge, count busy cycles,
  // check HI/LO stay frozen, optionally poke an MTLO mid-flight.
  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit inject, output int busy_n);
    int n, lat;
    bit stable;
    logic [31:0] oh, ol;
    lat = (op >= 3'd2) ? lat_div[d] : lat_mul[d];
    oh = m_hi[d];
    ol = m_lo[d];
    drive(d, 1'b1, op, a, b);
    @(negedge clk);
    drive(d, 1'b0, 3'd0, 32'd0, 32'd0);
    n = 0;
    stable = 1'b1;
    while (get_busy(d) && n < 200) begin
      n++;
      if (get_hi(d) !== oh || get_lo(d) !== ol) stable = 1'b0;
      if (inject && n == 2) drive(d, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
      if (inject && n == 3) drive(d, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
    drive(d, 1'b0, 3'd0, 32'd0, 32'd0);
    check($sformatf("busy_len d%0d op%0d", d, op), 64'(n), 64'(lat));
    check($sformatf("hilo_frozen d%0d op%0d", d, op), 64'(stable), 64'd1);
    check($sformatf("hi d%0d op%0d", d, op), 64'(get_hi(d)), 64'(exp_hi & wmask(d)));
    check($sformatf("lo d%0d op%0d", d, op), 64'(get_lo(d)), 64'(exp_lo & wmask(d)));
    m_hi[d] = exp_hi & wmask(d);
    m_lo[d] = exp_lo & wmask(d);
    busy_n = n;
  endtask

  // Single-cycle commands (MTHI/MTLO) and reserved ops
  task automatic mt_op(input int d, input logic [2:0] op, input logic [31:0] a);
    drive(d, 1'b1, op, a, 32'h5A5A_0F0F);
    @(negedge clk);
    drive(d, 1'b0, 3'd0, 32'd0, 32'd0);
    if (op == 3'd4) m_hi[d] = a & wmask(d);
    if (op == 3'd5) m_lo[d] = a & wmask(d);
    check($sformatf("mt_busy d%0d op%0d", d, op), 64'(get_busy(d)), 64'd0);
    check($sformatf("mt_hi d%0d op%0d", d, op), 64'(get_hi(d)), 64'(m_hi[d]));
    check($sformatf("mt_lo d%0d op%0d", d, op), 64'(get_lo(d)), 64'(m_lo[d]));
  endtask

  initial begin
    int n1, n2;
    logic [63:0] r;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int d;

    reset = 1'b0;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    repeat (2) @(negedge clk);
    check("rst_hi0", 64'(hi0), 64'd0);
    check("rst_lo0", 64'(lo0), 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases on the 32-bit instance
    run_op(0, 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, n1);
    run_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, n1);
    run_op(0, 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, n1);
    run_op(0, 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, n1);
    run_op(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, n1);
    run_op(0, 3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, n1);
    run_op(0, 3'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, n1);
    mt_op(0, 3'd4, 32'h0000_ABCD);
    check("mthi_literal", 64'(hi0), 64'h0000_ABCD);
    mt_op(0, 3'd5, 32'h1357_9BDF);
    mt_op(0, 3'd6, 32'hFFFF_0000);
    mt_op(0, 3'd7, 32'h0000_FFFF);
    run_op(0, 3'd0, 32'd6, 32'd7, 32'd0, 32'h0000_002A, 1'b1, n1);

    // Back-to-back: DIV issued in the cycle right after busy falls
    run_op(0, 3'd0, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b0, n1);
    run_op(0, 3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, n2);
    check("b2b_total32", 64'(n1 + n2), 64'd15);

    // Short-latency 16-bit instance
    run_op(1, 3'd0, 32'h0000_FFFE, 32'd3, 32'h0000_FFFF, 32'h0000_FFFA, 1'b0, n1);
    run_op(1, 3'd2, 32'h0000_FFF9, 32'd2, 32'h0000_FFFF, 32'h0000_FFFD, 1'b0, n2);
    check("b2b_total16", 64'(n1 + n2), 64'd4);
    run_op(1, 3'd2, 32'h0000_8000, 32'h0000_FFFF, 32'd0, 32'h0000_8000, 1'b0, n1);
    run_op(1, 3'd1, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 32'h0000_0001, 1'b0, n1);

    // Random commands against the reference model, both instances
    for (int i = 0; i < 40; i++) begin
      d   = i % 2;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: begin ra = (d == 0) ? 32'h8000_0000 : 32'h0000_8000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      ra = ra & wmask(d);
      rb = rb & wmask(d);
      if (rop <= 3'd3) begin
        r = ref_model(rop, ra, rb, wid[d]);
        run_op(d, rop, ra, rb, r[63:32], r[31:0], 1'b0, n1);
      end else begin
        mt_op(d, rop, ra);
      end
    end

    // Asynchronous reset in the middle of a MULT
    run_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, n1);
    drive(0, 1'b1, 3'd0, 32'd9, 32'd9);
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy0), 64'd1);
    reset = 1'b0;
    #1;
    check("async_rst_hi", 64'(hi0), 64'd0);
    check("async_rst_lo", 64'(lo0), 64'd0);
    check("async_rst_busy", 64'(busy0), 64'd0);
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    @(negedge clk);
    check("rst_hold_hi", 64'(hi0), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    run_op(0, 3'd0, 32'd5, 32'd5, 32'd0, 32'h0000_0019, 1'b0, n1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers, placed beside the combinational ALU in the execute stage of the pipelined CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and holds a configurable busy latency, which the hazard unit uses to stall MFHI/MFLO and further MDU commands.
- Generalises the datapath width and adds sequential behaviour (busy counter, result registers) that the plain ALU does not have.

Parameters:
- WIDTH, 32, operand and HI/LO register width (≥ 8).
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥ 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥ 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  command valid this cycle.
- op  input  3  command: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- a  input  WIDTH  operand rs.
- b  input  WIDTH  operand rt.
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, state IDLE. Reset mid-operation aborts the operation; the pending result is discarded.
- States:
  - IDLE → BUSY on start with op ∈ {0..3}.
  - BUSY → IDLE when the counter reaches 1 at a clock edge.
- Accept (IDLE and start=1, op 0–3):
  - Operands are sampled at that edge and the result is computed into internal pending registers.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- Timing:
  - busy stays high exactly N cycles (N = the latency for the op).
  - On the edge ending the N-th busy cycle, hi/lo load the pending result and busy falls.
  - Example: accept at edge 0, N=5 → busy high in cycles 1–5, hi/lo updated at edge 5, busy=0 in cycle 6.
- hi/lo never change during BUSY; the old values remain readable.
- MTHI/MTLO (start=1, op 4/5, IDLE):
  - hi (or lo) := a at that edge.
  - busy stays 0; no state change.
- Commands while BUSY: start is ignored for every op. The hazard unit guarantees stalls; the MDU must not corrupt state if this is violated.
- Reserved op 6–7: ignored, no state change.
- MULT:
  - Signed WIDTH×WIDTH → 2·WIDTH product.
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
- MULTU: the same, unsigned.
- DIV:
  - Signed division, quotient truncated toward zero.
  - lo = quotient; hi = remainder, which takes the sign of the dividend.
  - Overflow (a = most negative, b = −1): lo = a, hi = 0.
- DIVU: unsigned; lo = quotient, hi = remainder.
- Divide by zero (DIV or DIVU, b = 0):
  - Still busy for DIV_CYCLES.
  - Result: lo = all ones, hi = a.
- Simultaneous events: busy falls at the edge where hi/lo update; a new start in the following cycle is accepted normally. start is not accepted in the same cycle that busy is high.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - state encoding: IDLE, BUSY.
  - default latency constants.
- One combinational sub-module, mdu_compute:
  - inputs: op, a, b; outputs: res_hi, res_lo.
  - handles the signed/unsigned rules, the divide-overflow rule and the divide-by-zero rule.
- The top level holds the FSM, counter, pending registers and HI/LO registers.

Test Plan:
- Reset: hold reset=0 mid-MULT (busy=1) → hi=lo=0 and busy=0 immediately; after release, the first start is accepted.
- Signed MULT: WIDTH=32, a=0xFFFFFFFE (−2), b=3 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo keep old values while busy.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV with negatives: a=−7 (0xFFFFFFF9), b=2 → busy 10 cycles, then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU: a=7, b=2 → lo=3, hi=1.
- DIV boundary cases:
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- MTHI/MTLO and ignore rules:
  - MTHI a=0xABCD → hi=0xABCD next cycle, busy stays 0.
  - MTLO issued during BUSY → ignored; the final lo equals the MULT result.
- Back-to-back: MULT, then DIV started in the cycle after busy falls → accepted; total busy = 5 + 10 cycles with a one-cycle gap. Repeat with WIDTH=16, MULT_CYCLES=1 for parameter coverage.
